// File: rtl/vram_port_arbiter_if.sv
// Bundle for the video fetch port, CPU data port and the single-port RAM command/return path.
// master = requesters plus RAM model side, slave = the arbiter.
interface vram_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Video/CPU arbiter for one single-port RAM; VRAM_ARB_STATS_EN adds a CPU stall counter.
// Latency: grant same cycle, RAM command next cycle, read data 1+RD_LAT cycles after transfer.
// Backpressure: video has priority, CPU is forced through after MAX_VID_STREAK video wins.
module vram_port_arbiter #(
  parameter int AW             = 16,
  parameter int DW             = 32,
  parameter int RD_LAT         = 1,
  parameter int MAX_VID_STREAK = 8
) (
  input  logic               clk,
  input  logic               reset,
  vram_port_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]        cpu_stall_cnt
`endif
);

  localparam int SW = $clog2(MAX_VID_STREAK + 1);

  logic [SW-1:0]     vid_streak;
  logic              streak_full;
  logic              vid_win;
  logic              cpu_win;

  logic [AW-1:0]     addr_q;
  logic              we_q;
  logic [DW-1:0]     wdata_q;
  logic              cmd_rd;
  logic              cmd_cpu;

  logic [RD_LAT-1:0] tag_vld;
  logic [RD_LAT-1:0] tag_cpu;
  logic              vid_rv;
  logic              cpu_rv;
  logic [DW-1:0]     vid_hold;
  logic [DW-1:0]     cpu_hold;

  // Grants gated by reset so nothing is accepted in a reset cycle.
  assign streak_full = (vid_streak == SW'(MAX_VID_STREAK));
  assign vid_win     = !reset && bus.vid_req && !(bus.cpu_req && streak_full);
  assign cpu_win     = !reset && bus.cpu_req && (!bus.vid_req || streak_full);

  assign bus.vid_gnt = vid_win;
  assign bus.cpu_gnt = cpu_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid_streak <= '0;
    end else if (cpu_win || !bus.cpu_req) begin
      vid_streak <= '0;
    end else if (vid_win && !streak_full) begin
      vid_streak <= vid_streak + SW'(1);
    end
  end

  // Command stage also carries the read tag for the cycle the address is on the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cmd_rd  <= 1'b0;
      cmd_cpu <= 1'b0;
    end else if (vid_win) begin
      addr_q  <= bus.vid_addr;
      we_q    <= 1'b0;
      cmd_rd  <= 1'b1;
      cmd_cpu <= 1'b0;
    end else if (cpu_win) begin
      addr_q  <= bus.cpu_addr;
      we_q    <= bus.cpu_we;
      wdata_q <= bus.cpu_wdata;
      cmd_rd  <= !bus.cpu_we;
      cmd_cpu <= 1'b1;
    end else begin
      we_q    <= 1'b0;
      cmd_rd  <= 1'b0;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld  <= '0;
      tag_cpu  <= '0;
      vid_hold <= '0;
      cpu_hold <= '0;
    end else begin
      tag_vld[0] <= cmd_rd;
      tag_cpu[0] <= cmd_cpu;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_cpu[i] <= tag_cpu[i-1];
      end
      if (vid_rv) vid_hold <= bus.mem_rdata;
      if (cpu_rv) cpu_hold <= bus.mem_rdata;
    end
  end

  // Return data is passed straight through on the rvalid cycle, then held.
  assign vid_rv = !reset && tag_vld[RD_LAT-1] && !tag_cpu[RD_LAT-1];
  assign cpu_rv = !reset && tag_vld[RD_LAT-1] &&  tag_cpu[RD_LAT-1];

  assign bus.vid_rvalid = vid_rv;
  assign bus.cpu_rvalid = cpu_rv;
  assign bus.vid_rdata  = vid_rv ? bus.mem_rdata : vid_hold;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : cpu_hold;

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_stall_cnt <= '0;
    end else if (bus.cpu_req && !cpu_win && cpu_stall_cnt != 16'hFFFF) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: RAM model, scoreboard of expected read returns.
module tb_vram_port_arbiter;
  localparam int AW     = 16;
  localparam int DW     = 32;
  localparam int RD_LAT = 3;
  localparam int MAXS   = 8;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] cpu_stall_cnt;
`endif

  vram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_VID_STREAK(MAXS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef VRAM_ARB_STATS_EN
    ,
    .cpu_stall_cnt (cpu_stall_cnt)
`endif
  );

  // RAM model: synchronous write, RD_LAT-cycle read pipeline
  logic [DW-1:0] ram       [0:(1<<AW)-1];
  logic [DW-1:0] model_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe   [RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= ram[bus.mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    logic          own_cpu;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  // Monitor: rvalid checks against the scoreboard, then records new transfers.
  always @(negedge clk) begin
    if (bus.vid_rvalid || bus.cpu_rvalid) begin
      tests_run++;
      if (bus.vid_rvalid && bus.cpu_rvalid) begin
        fails++;
        $display("FAIL both_rvalid: vid=1 cpu=1, required at most one at cycle %0d", cyc);
      end else if (sbq.size() == 0) begin
        fails++;
        $display("FAIL spurious_rvalid: vid=%0b cpu=%0b at cycle %0d, required none", bus.vid_rvalid, bus.cpu_rvalid, cyc);
      end else begin
        e = sbq.pop_front();
        if (bus.cpu_rvalid !== e.own_cpu ||
            (bus.cpu_rvalid ? bus.cpu_rdata : bus.vid_rdata) !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL read_return: got cpu=%0b data=%h cycle=%0d, required cpu=%0b data=%h cycle=%0d",
                   bus.cpu_rvalid, bus.cpu_rvalid ? bus.cpu_rdata : bus.vid_rdata, cyc,
                   e.own_cpu, e.data, e.due);
        end
      end
    end
    if (reset) begin
      sbq.delete();
    end else begin
      tests_run++;
      if ((bus.vid_gnt && bus.cpu_gnt) || (bus.vid_gnt && !bus.vid_req) || (bus.cpu_gnt && !bus.cpu_req)) begin
        fails++;
        $display("FAIL gnt_rules: vid_gnt=%0b cpu_gnt=%0b vid_req=%0b cpu_req=%0b, required one gnt max and only with req",
                 bus.vid_gnt, bus.cpu_gnt, bus.vid_req, bus.cpu_req);
      end
      if (bus.vid_req && bus.vid_gnt)
        sbq.push_back('{1'b0, model_mem[bus.vid_addr], cyc + 1 + RD_LAT});
      if (bus.cpu_req && bus.cpu_gnt) begin
        if (bus.cpu_we) model_mem[bus.cpu_addr] = bus.cpu_wdata;
        else sbq.push_back('{1'b1, model_mem[bus.cpu_addr], cyc + 1 + RD_LAT});
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) step();
    tests_run++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d reads outstanding, required 0", sbq.size());
    end
  endtask

  task automatic idle_reqs();
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.vid_req = 1'b1;
    bus.cpu_req = 1'b1;
    repeat (2) step();
    @(negedge clk);
    tests_run++;
    if ({bus.vid_gnt, bus.cpu_gnt, bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: gnt/we/rvalid=%b, required 00000",
               {bus.vid_gnt, bus.cpu_gnt, bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid});
    end
    tests_run++;
    if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_mem: addr=%h wdata=%h, required 0", bus.mem_addr, bus.mem_wdata);
    end
    tests_run++;
    if (bus.vid_rdata !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_rdata: vid=%h cpu=%h, required 0", bus.vid_rdata, bus.cpu_rdata);
    end
    step();
    idle_reqs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_cpu_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    @(negedge clk);
    tests_run++;
    if (bus.cpu_gnt !== 1'b1 || bus.vid_gnt !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_gnt: cpu_gnt=%b vid_gnt=%b, required 1 0", bus.cpu_gnt, bus.vid_gnt);
    end
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_addr !== 16'h0010 || bus.mem_we !== 1'b0) begin
      fails++;
      $display("FAIL cpu_read_cmd: mem_addr=%h mem_we=%b, required 0010 0", bus.mem_addr, bus.mem_we);
    end
    step();
    drain();
    repeat (2) step();
    tests_run++;
    if (bus.cpu_rdata !== model_mem[16'h0010] || bus.cpu_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL cpu_rdata_hold: rdata=%h rvalid=%b, required %h 0", bus.cpu_rdata, bus.cpu_rvalid, model_mem[16'h0010]);
    end
  endtask

  task automatic test_priority_streak();
    logic exp_v;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0200;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0300;
    for (int i = 0; i < 2 * (MAXS + 1); i++) begin
      exp_v = ((i % (MAXS + 1)) != MAXS);
      @(negedge clk);
      tests_run++;
      if (bus.vid_gnt !== exp_v || bus.cpu_gnt !== !exp_v) begin
        fails++;
        $display("FAIL streak_cycle%0d: vid_gnt=%b cpu_gnt=%b, required %b %b", i, bus.vid_gnt, bus.cpu_gnt, exp_v, !exp_v);
      end
      step();
      if (exp_v) bus.vid_addr = bus.vid_addr + 16'd1;
    end
    idle_reqs();
    drain();
  endtask

  task automatic test_write_then_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++;
    if (bus.cpu_gnt !== 1'b1) begin
      fails++;
      $display("FAIL wr_gnt: cpu_gnt=%b, required 1", bus.cpu_gnt);
    end
    step();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0100;
    @(negedge clk);
    tests_run++;
    if (bus.vid_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0100 || bus.mem_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL wr_cmd: vid_gnt=%b we=%b addr=%h wdata=%h, required 1 1 0100 deadbeef",
               bus.vid_gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    step();
    bus.vid_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0100) begin
      fails++;
      $display("FAIL wr_pulse: we=%b addr=%h, required 0 0100", bus.mem_we, bus.mem_addr);
    end
    step();
    drain();
    tests_run++;
    if (bus.vid_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL raw_vid_rdata: %h, required deadbeef", bus.vid_rdata);
    end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < 16; i++) begin
      bus.vid_req  = (i % 2 == 0);
      bus.cpu_req  = (i % 2 == 1);
      bus.cpu_we   = 1'b0;
      bus.vid_addr = 16'($urandom);
      bus.cpu_addr = 16'($urandom);
      @(negedge clk);
      tests_run++;
      if (bus.vid_gnt !== bus.vid_req || bus.cpu_gnt !== bus.cpu_req) begin
        fails++;
        $display("FAIL alt_gnt%0d: vid_gnt=%b cpu_gnt=%b, required %b %b", i, bus.vid_gnt, bus.cpu_gnt, bus.vid_req, bus.cpu_req);
      end
      step();
    end
    idle_reqs();
    drain();
  endtask

  task automatic test_back_to_back();
    logic vg, cg;
    for (int i = 0; i < 60; i++) begin
      if (!bus.vid_req && $urandom_range(0, 3) != 0) begin
        bus.vid_req = 1'b1; bus.vid_addr = 16'($urandom_range(0, 15));
      end
      if (!bus.cpu_req && $urandom_range(0, 3) != 0) begin
        bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 16'($urandom_range(0, 15)); bus.cpu_wdata = $urandom;
      end
      @(negedge clk);
      vg = bus.vid_gnt;
      cg = bus.cpu_gnt;
      tests_run++;
      if ((bus.vid_req || bus.cpu_req) && !(vg || cg)) begin
        fails++;
        $display("FAIL b2b_idle%0d: no gnt with vid_req=%b cpu_req=%b, required one gnt", i, bus.vid_req, bus.cpu_req);
      end
      step();
      if (vg) bus.vid_req = 1'b0;
      if (cg) bus.cpu_req = 1'b0;
    end
    idle_reqs();
    drain();
  endtask

  task automatic test_reset_midread();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
    @(negedge clk);
    tests_run++;
    if (bus.cpu_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_gnt: cpu_gnt=%b, required 1", bus.cpu_gnt);
    end
    step();
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0040;
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.vid_gnt !== 1'b0) begin
      fails++;
      $display("FAIL rst_gnt_gate: vid_gnt=%b during reset, required 0", bus.vid_gnt);
    end
    step();
    reset = 1'b0;
    bus.vid_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid} !== 3'b0 || bus.mem_addr !== 16'h0 ||
        bus.mem_wdata !== 32'h0 || bus.vid_rdata !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rst_outputs: we=%b rv=%b%b addr=%h wdata=%h vrd=%h crd=%h, required all 0",
               bus.mem_we, bus.vid_rvalid, bus.cpu_rvalid, bus.mem_addr, bus.mem_wdata, bus.vid_rdata, bus.cpu_rdata);
    end
    repeat (RD_LAT + 3) step();
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0030;
    @(negedge clk);
    tests_run++;
    if (bus.vid_gnt !== 1'b1) begin
      fails++;
      $display("FAIL rst_post_gnt: vid_gnt=%b, required 1", bus.vid_gnt);
    end
    step();
    bus.vid_req = 1'b0;
    drain();
  endtask

`ifdef VRAM_ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0050;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0060;
    repeat (MAXS + 1) step();
    tests_run++;
    if (cpu_stall_cnt !== 16'd8) begin
      fails++;
      $display("FAIL stall_cnt8: %0d, required 8", cpu_stall_cnt);
    end
    repeat (74000) step();
    tests_run++;
    if (cpu_stall_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL stall_sat: %h, required ffff", cpu_stall_cnt);
    end
    idle_reqs();
    drain();
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]       = i * 32'h9E3779B1 + 32'h1234;
      model_mem[i] = i * 32'h9E3779B1 + 32'h1234;
    end
    test_reset();
    test_cpu_read();
    test_priority_streak();
    test_write_then_read();
    test_alternating();
    test_back_to_back();
    test_reset_midread();
`ifdef VRAM_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
